anton_neopixel_decoder: RTL and testbench
=========================================

Name: anton_neopixel_decoder

Overview:
- Receive-side counterpart of the NeoPixel stream transmitter.
- Samples a WS2812-style single-wire stream at 6.4 MHz, measures each high pulse, and classifies it as a 0 or 1 bit.
- Assembles bits MSB-first into bytes, emits each byte with its buffer index, and flags frame boundaries (sync gaps) and protocol errors.
- Used for loopback verification of the transmitter and for daisy-chain monitoring.

Parameters:
- BUFFER_END, 63: last valid byte index; bytes with a higher index are discarded.
- SYNC_CYCLES, 320: consecutive low samples that form a sync/latch gap (50 us at 6.4 MHz); minimum 16.
- T1_MIN_HIGH, 4: high-run length (in samples) at or above which a bit decodes as 1; below it decodes as 0.
- MAX_HIGH, 7: longest legal high run; anything longer is an error.

Ports:
- clk6_4mhz  input  1  sample/system clock
- reset  input  1  synchronous, active-high reset
- enable  input  1  decoder enable; low forces IDLE
- neoData  input  1  serial NeoPixel line
- dataOut  output  8  last completed byte
- dataValid  output  1  one-cycle pulse; dataOut and byteIndex valid
- byteIndex  output  13  index of dataOut within the frame (0-based)
- frameDone  output  1  one-cycle pulse at the end of a frame
- frameBytes  output  13  bytes stored in the last completed frame
- errorPulse  output  1  one-cycle pulse on an error
- errorCode  output  2  1 = high too long, 2 = sync inside byte, 3 = overflow; holds until the next error
- busy  output  1  state is HIGH or LOW

Behaviour:
- Internal sample register s holds neoData. Edges are detected by comparing s with the previous sample.
- Internal counters:
  - highCnt: 4 bits, saturating.
  - lowCnt: CLOG2(SYNC_CYCLES+1) bits, saturating at SYNC_CYCLES.
  - bitCnt: 3 bits.
  - shift register: 8 bits.
  - idx: 13 bits.
- reset or !enable (synchronous):
  - State goes to IDLE; all counters clear.
  - All outputs go to 0: dataOut, byteIndex, frameBytes, errorCode, and every pulse output.
- Pulse outputs are registered and high for exactly one cycle. No pulse is generated while reset or !enable is asserted.
- IDLE (not synchronised):
  - Each low sample increments lowCnt; a high sample clears it.
  - When lowCnt reaches SYNC_CYCLES, go to ARMED. frameDone is not generated.
- ARMED:
  - Rising edge: go to HIGH with highCnt=1, bitCnt=0, idx=0.
- HIGH:
  - Each high sample increments highCnt.
  - If highCnt would exceed MAX_HIGH: errorCode=1, errorPulse, discard the partial byte, go to IDLE (re-sync required).
  - Falling edge: bit = (highCnt >= T1_MIN_HIGH). Shift the bit into the LSB, increment bitCnt, set lowCnt=1, go to LOW.
  - When bitCnt wraps 7→0, the byte is complete:
    - If idx <= BUFFER_END: dataOut = byte, byteIndex = idx, dataValid pulses in the next cycle.
    - If idx > BUFFER_END: the byte is dropped. errorCode=3 and errorPulse fire once per frame, on the first overflowing byte.
    - idx increments, saturating at 8191.
- LOW:
  - Rising edge: go to HIGH with highCnt=1.
  - Gaps between bits shorter than SYNC_CYCLES are tolerated and carry no penalty.
  - When lowCnt reaches SYNC_CYCLES:
    - bitCnt == 0 and idx > 0: frameDone pulses and frameBytes = min(idx, BUFFER_END+1).
    - bitCnt != 0: errorCode=2, errorPulse, partial byte discarded, no frameDone. If complete bytes were received, frameBytes is still not updated.
    - In both cases go to ARMED; the next rising edge starts a new frame with idx=0.
- Simultaneous events:
  - Byte completion and overflow on the same edge: the overflow error takes the slot; no dataValid.
  - errorCode reports only the most recent error.
- Latency: dataValid is asserted 1 cycle after the clock edge that samples the 8th falling edge (+2 cycles with the synchroniser, see below).

Optional Feature:
- Macro: ANTON_NEOPIXEL_DECODER_SYNC_EN.
- Defined: neoData passes through a 2-flop synchroniser before s. All decode latencies increase by exactly 2 cycles. Use when neoData is asynchronous, e.g. external pin loopback.
- Undefined: neoData is registered directly into s. For on-chip loopback from the clk6_4mhz transmitter domain.
- Bit-classification results are identical with and without the macro.

Test Plan:
- Sync then byte: 320 low samples, then 8 bits as 0x A5 (1 = 5 high/3 low, 0 = 2 high/6 low), then 320 low → dataValid once with dataOut=0xA5, byteIndex=0; then frameDone with frameBytes=1.
- Threshold boundaries: high runs of 3 and 4 samples → bits 0 and 1 respectively. A high run of 8 → errorCode=1, errorPulse, no dataValid; the next byte is ignored until a 320-sample low gap.
- Partial byte: sync, 5 bits, 320 low → errorCode=2, no frameDone, no dataValid; the following full frame decodes normally.
- Overflow with BUFFER_END=1: frame of 3 bytes 0x01,0x02,0x03 → dataValid for the first two only, one errorPulse with code 3, frameDone with frameBytes=2.
- Disruption mid-frame: assert reset during bit 4 of byte 1 → all outputs 0, state IDLE; deassert reset, send a full sync-framed byte → that byte decodes correctly. Repeat using enable=0 instead of reset.
- Without sync: first rising edge after reset with fewer than 320 low samples → no output; with ANTON_NEOPIXEL_DECODER_SYNC_EN defined, the first scenario shows dataValid 2 cycles later than without the macro.

Source files
------------

// File: rtl/anton_neopixel_decoder.sv
// anton_neopixel_decoder: samples a WS2812-style line at 6.4 MHz, classifies
// each high pulse as a 0/1 bit, assembles MSB-first bytes with their frame
// index, and flags sync-gap frame boundaries and protocol errors.
// Optional: define ANTON_NEOPIXEL_DECODER_SYNC_EN to pass neoData through a
// 2-flop synchroniser first (all decode latencies grow by 2 cycles).
module anton_neopixel_decoder #(
    parameter int BUFFER_END  = 63,
    parameter int SYNC_CYCLES = 320,
    parameter int T1_MIN_HIGH = 4,
    parameter int MAX_HIGH    = 7
) (
    input  logic        clk6_4mhz,
    input  logic        reset,
    input  logic        enable,
    input  logic        neoData,
    output logic [7:0]  dataOut,
    output logic        dataValid,
    output logic [12:0] byteIndex,
    output logic        frameDone,
    output logic [12:0] frameBytes,
    output logic        errorPulse,
    output logic [1:0]  errorCode,
    output logic        busy
);

    localparam int LW = $clog2(SYNC_CYCLES + 1);
    localparam logic [LW-1:0] LOW_SYNC  = LW'(SYNC_CYCLES);
    localparam logic [3:0]    HIGH_MAX  = 4'(MAX_HIGH);
    localparam logic [3:0]    HIGH_ONE  = 4'(T1_MIN_HIGH);
    localparam logic [12:0]   IDX_LAST  = 13'(BUFFER_END);
    localparam logic [12:0]   FRAME_MAX = 13'(BUFFER_END + 1);

    typedef enum logic [1:0] {IDLE, ARMED, HIGH, LOW} state_t;

    logic clear;
    logic sIn, s, prev;

    state_t        state, stateNext;
    logic [3:0]    highCnt, highNext;
    logic [LW-1:0] lowCnt, lowNext;
    logic [2:0]    bitCnt, bitNext;
    logic [7:0]    shiftReg, shiftNext;
    logic [12:0]   idx, idxNext;
    logic          ovfSeen, ovfNext;
    logic [7:0]    dataOutNext;
    logic [12:0]   byteIndexNext, frameBytesNext;
    logic [1:0]    errorCodeNext;
    logic          dataValidNext, frameDoneNext, errorPulseNext;

    logic [3:0]    highInc;
    logic [LW-1:0] lowInc;
    logic [12:0]   idxInc, frameCount;
    logic          bitVal;
    logic [7:0]    byteVal;

    assign clear = reset | ~enable;

`ifdef ANTON_NEOPIXEL_DECODER_SYNC_EN
    logic [1:0] syncFf;

    // Two-flop synchroniser for an asynchronous line
    always_ff @(posedge clk6_4mhz) begin
        if (clear) syncFf <= '0;
        else       syncFf <= {syncFf[0], neoData};
    end

    assign sIn = syncFf[1];
`else
    assign sIn = neoData;
`endif

    // Line sample and previous sample for edge detection
    always_ff @(posedge clk6_4mhz) begin
        if (clear) begin
            s    <= 1'b0;
            prev <= 1'b0;
        end else begin
            s    <= sIn;
            prev <= s;
        end
    end

    assign highInc    = (highCnt == 4'hF) ? highCnt : highCnt + 4'd1;
    assign lowInc     = (lowCnt == LOW_SYNC) ? lowCnt : lowCnt + 1'b1;
    assign idxInc     = (idx == '1) ? idx : idx + 13'd1;
    assign frameCount = (idx > IDX_LAST) ? FRAME_MAX : idx;
    assign bitVal     = (highCnt >= HIGH_ONE);
    assign byteVal    = {shiftReg[6:0], bitVal};
    assign busy       = (state == HIGH) || (state == LOW);

    // Decoder state, counters and registered outputs
    always_ff @(posedge clk6_4mhz) begin
        if (clear) begin
            state      <= IDLE;
            highCnt    <= '0;
            lowCnt     <= '0;
            bitCnt     <= '0;
            shiftReg   <= '0;
            idx        <= '0;
            ovfSeen    <= 1'b0;
            dataOut    <= '0;
            byteIndex  <= '0;
            frameBytes <= '0;
            errorCode  <= '0;
            dataValid  <= 1'b0;
            frameDone  <= 1'b0;
            errorPulse <= 1'b0;
        end else begin
            state      <= stateNext;
            highCnt    <= highNext;
            lowCnt     <= lowNext;
            bitCnt     <= bitNext;
            shiftReg   <= shiftNext;
            idx        <= idxNext;
            ovfSeen    <= ovfNext;
            dataOut    <= dataOutNext;
            byteIndex  <= byteIndexNext;
            frameBytes <= frameBytesNext;
            errorCode  <= errorCodeNext;
            dataValid  <= dataValidNext;
            frameDone  <= frameDoneNext;
            errorPulse <= errorPulseNext;
        end
    end

    // Next-state, counter and output decode
    always_comb begin
        stateNext      = state;
        highNext       = highCnt;
        lowNext        = lowCnt;
        bitNext        = bitCnt;
        shiftNext      = shiftReg;
        idxNext        = idx;
        ovfNext        = ovfSeen;
        dataOutNext    = dataOut;
        byteIndexNext  = byteIndex;
        frameBytesNext = frameBytes;
        errorCodeNext  = errorCode;
        dataValidNext  = 1'b0;
        frameDoneNext  = 1'b0;
        errorPulseNext = 1'b0;

        case (state)
            IDLE: begin
                if (s) begin
                    lowNext = '0;
                end else begin
                    lowNext = lowInc;
                    if (lowInc == LOW_SYNC) stateNext = ARMED;
                end
            end
            ARMED: begin
                if (s && !prev) begin
                    stateNext = HIGH;
                    highNext  = 4'd1;
                    bitNext   = '0;
                    shiftNext = '0;
                    idxNext   = '0;
                    ovfNext   = 1'b0;
                end
            end
            HIGH: begin
                if (s) begin
                    if (highCnt >= HIGH_MAX) begin
                        errorCodeNext  = 2'd1;
                        errorPulseNext = 1'b1;
                        bitNext        = '0;
                        shiftNext      = '0;
                        lowNext        = '0;
                        stateNext      = IDLE;
                    end else begin
                        highNext = highInc;
                    end
                end else begin
                    shiftNext = byteVal;
                    bitNext   = bitCnt + 3'd1;
                    lowNext   = LW'(1);
                    stateNext = LOW;
                    if (bitCnt == 3'd7) begin
                        // An overflowing byte never produces dataValid
                        if (idx <= IDX_LAST) begin
                            dataOutNext   = byteVal;
                            byteIndexNext = idx;
                            dataValidNext = 1'b1;
                        end else if (!ovfSeen) begin
                            errorCodeNext  = 2'd3;
                            errorPulseNext = 1'b1;
                            ovfNext        = 1'b1;
                        end
                        idxNext = idxInc;
                    end
                end
            end
            LOW: begin
                if (s) begin
                    stateNext = HIGH;
                    highNext  = 4'd1;
                end else begin
                    lowNext = lowInc;
                    if (lowInc == LOW_SYNC) begin
                        stateNext = ARMED;
                        bitNext   = '0;
                        if (bitCnt != 3'd0) begin
                            errorCodeNext  = 2'd2;
                            errorPulseNext = 1'b1;
                        end else if (idx != 13'd0) begin
                            frameDoneNext  = 1'b1;
                            frameBytesNext = frameCount;
                        end
                    end
                end
            end
            default: stateNext = IDLE;
        endcase
    end

endmodule

// File: tb/tb_anton_neopixel_decoder.sv
// Self-checking bench for anton_neopixel_decoder (BUFFER_END overridden to 1).
module tb_anton_neopixel_decoder;

    localparam int BE   = 1;
    localparam int SYNC = 320;
    localparam int T1   = 4;
    localparam int MAXH = 7;
`ifdef ANTON_NEOPIXEL_DECODER_SYNC_EN
    localparam int LAT = 4;
`else
    localparam int LAT = 2;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        enable = 1'b1;
    logic        neoData = 1'b0;
    logic [7:0]  dataOut;
    logic        dataValid;
    logic [12:0] byteIndex;
    logic        frameDone;
    logic [12:0] frameBytes;
    logic        errorPulse;
    logic [1:0]  errorCode;
    logic        busy;

    anton_neopixel_decoder #(.BUFFER_END(BE), .SYNC_CYCLES(SYNC),
                             .T1_MIN_HIGH(T1), .MAX_HIGH(MAXH)) dut (
        .clk6_4mhz(clk), .reset(reset), .enable(enable), .neoData(neoData),
        .dataOut(dataOut), .dataValid(dataValid), .byteIndex(byteIndex),
        .frameDone(frameDone), .frameBytes(frameBytes),
        .errorPulse(errorPulse), .errorCode(errorCode), .busy(busy)
    );

    always #5 clk = ~clk;

    // kind: 1 = byte (a=data, b=index), 2 = frame (a=bytes), 3 = error (a=code)
    typedef struct {int kind; int a; int b; int cyc;} ev_t;
    typedef struct {
        logic [7:0] pat;
        int h0, l0, h1, l1;
        int nData; logic [7:0] expData;
        int nErr;  int expCode;
    } vec_t;

    ev_t  gotQ[$], expQ[$], modelQ[$];
    vec_t vecs[7];
    int   cyc = 0;
    int   checks = 0, errors = 0;
    int   gStart = 0, lastFall = 0, fc = 0, found = 0;
    int   nb = 0, bitv = 0, h = 0, g = 0, r = 0;

    // Pulse-level reference model state
    int   mState = 0, idleLow = 0, lowRun = 0, bits = 0, acc = 0, idx = 0, ovf = 0;
    int   hiRun = 0;
    logic curLvl = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (dataValid)  gotQ.push_back('{1, int'(dataOut), int'(byteIndex), cyc});
        if (frameDone)  gotQ.push_back('{2, int'(frameBytes), 0, cyc});
        if (errorPulse) gotQ.push_back('{3, int'(errorCode), 0, cyc});
    end

    task automatic chk(input string name, input int got, input int want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, got, want);
        end
    endtask

    function automatic void modelRise();
        lowRun = 0;
        if (mState == 0) idleLow = 0;
    endfunction

    function automatic void modelLow(input int len);
        if (mState == 0) begin
            idleLow += len;
            if (idleLow >= SYNC) mState = 1;
        end else if (mState == 2) begin
            lowRun += len;
            if (lowRun >= SYNC) begin
                if (bits != 0)    modelQ.push_back('{3, 2, 0, 0});
                else if (idx > 0) modelQ.push_back('{2, (idx < BE + 1) ? idx : BE + 1, 0, 0});
                mState = 1;
            end
        end
    endfunction

    function automatic void modelHigh(input int len);
        if (mState == 0) return;
        if (mState == 1) begin
            mState = 2; idx = 0; bits = 0; acc = 0; ovf = 0;
        end
        if (len > MAXH) begin
            modelQ.push_back('{3, 1, 0, 0});
            mState = 0; idleLow = 0;
            return;
        end
        acc = ((acc << 1) | ((len >= T1) ? 1 : 0)) & 255;
        bits++;
        if (bits == 8) begin
            bits = 0;
            if (idx <= BE) modelQ.push_back('{1, acc, idx, 0});
            else if (ovf == 0) begin
                modelQ.push_back('{3, 3, 0, 0});
                ovf = 1;
            end
            if (idx < 8191) idx++;
        end
    endfunction

    function automatic void modelReset();
        mState = 0; idleLow = 0; lowRun = 0; hiRun = 0; curLvl = 1'b0;
    endfunction

    task automatic drive(input logic lvl, input int len);
        logic fall;
        if (len <= 0) return;
        fall = !lvl && curLvl;
        if (lvl && !curLvl) modelRise();
        if (fall) begin
            modelHigh(hiRun);
            hiRun = 0;
        end
        curLvl = lvl;
        for (int i = 0; i < len; i++) begin
            @(negedge clk);
            neoData = lvl;
            if (i == 0 && fall) lastFall = cyc;
        end
        if (lvl) hiRun += len;
        else     modelLow(len);
    endtask

    task automatic sendByte(input logic [7:0] v, input int h0, input int l0,
                            input int h1, input int l1);
        for (int i = 7; i >= 0; i--) begin
            if (v[i]) begin drive(1'b1, h1); drive(1'b0, l1); end
            else      begin drive(1'b1, h0); drive(1'b0, l0); end
        end
    endtask

    task automatic sendBits(input logic [7:0] v, input int n);
        for (int i = 0; i < n; i++) begin
            if (v[7 - i]) begin drive(1'b1, 5); drive(1'b0, 3); end
            else          begin drive(1'b1, 2); drive(1'b0, 6); end
        end
    endtask

    task automatic beginScen();
        gStart = gotQ.size();
        expQ.delete();
        modelQ.delete();
    endtask

    task automatic expPush(input int k, input int a, input int b);
        expQ.push_back('{k, a, b, 0});
    endtask

    task automatic compareQ(input string name);
        int n;
        n = gotQ.size() - gStart;
        chk({name, " count"}, n, expQ.size());
        for (int i = 0; i < n && i < expQ.size(); i++) begin
            chk($sformatf("%s ev%0d kind", name, i), gotQ[gStart + i].kind, expQ[i].kind);
            chk($sformatf("%s ev%0d a", name, i), gotQ[gStart + i].a, expQ[i].a);
            chk($sformatf("%s ev%0d b", name, i), gotQ[gStart + i].b, expQ[i].b);
        end
    endtask

    task automatic checkCleared(input string name);
        chk({name, " dataOut"}, int'(dataOut), 0);
        chk({name, " byteIndex"}, int'(byteIndex), 0);
        chk({name, " frameBytes"}, int'(frameBytes), 0);
        chk({name, " errorCode"}, int'(errorCode), 0);
        chk({name, " dataValid"}, int'(dataValid), 0);
        chk({name, " frameDone"}, int'(frameDone), 0);
        chk({name, " errorPulse"}, int'(errorPulse), 0);
        chk({name, " busy"}, int'(busy), 0);
    endtask

    task automatic doReset(input logic useEnable, input string name);
        @(negedge clk);
        if (useEnable) enable = 1'b0;
        else           reset  = 1'b1;
        neoData = 1'b0;
        repeat (3) @(negedge clk);
        checkCleared(name);
        reset  = 1'b0;
        enable = 1'b1;
        modelReset();
    endtask

    initial begin
        vecs[0] = '{8'hA5, 2, 6, 5, 3, 1, 8'hA5, 0, 0};
        vecs[1] = '{8'h3C, 3, 1, 4, 1, 1, 8'h3C, 0, 0};
        vecs[2] = '{8'h81, 1, 1, 7, 1, 1, 8'h81, 0, 0};
        vecs[3] = '{8'h5A, 3, 8, 4, 20, 1, 8'h5A, 0, 0};
        vecs[4] = '{8'hFF, 2, 2, 8, 3, 0, 8'h00, 1, 1};
        vecs[5] = '{8'h00, 3, 319, 4, 1, 1, 8'h00, 0, 0};
        vecs[6] = '{8'h7F, 2, 320, 5, 3, 0, 8'h00, 2, 2};

        repeat (4) @(negedge clk);
        checkCleared("reset");
        reset = 1'b0;
        modelReset();

        // Table: one sync-framed byte per vector
        for (int v = 0; v < 7; v++) begin
            beginScen();
            drive(1'b0, 330);
            sendByte(vecs[v].pat, vecs[v].h0, vecs[v].l0, vecs[v].h1, vecs[v].l1);
            fc = lastFall;
            drive(1'b0, 330);
            if (vecs[v].nData != 0) begin
                expPush(1, int'(vecs[v].expData), 0);
                expPush(2, 1, 0);
            end
            for (int e = 0; e < vecs[v].nErr; e++) expPush(3, vecs[v].expCode, 0);
            compareQ($sformatf("vec%0d", v));
            if (vecs[v].nErr > 0) chk($sformatf("vec%0d errorCode", v), int'(errorCode), vecs[v].expCode);
            if (v == 0) begin
                found = -1;
                for (int i = gStart; i < gotQ.size(); i++)
                    if (gotQ[i].kind == 1 && found < 0) found = gotQ[i].cyc - fc;
                chk("latency", found, LAT);
                chk("frameBytes vec0", int'(frameBytes), 1);
            end
        end

        // Re-sync from IDLE needs exactly SYNC low samples
        beginScen();
        drive(1'b1, 9);
        drive(1'b0, SYNC - 1);
        sendBits(8'h55, 8);
        drive(1'b0, 330);
        drive(1'b1, 8);
        drive(1'b0, SYNC);
        sendBits(8'h66, 8);
        drive(1'b0, 330);
        expPush(3, 1, 0); expPush(3, 1, 0); expPush(1, 8'h66, 0); expPush(2, 1, 0);
        compareQ("idleSync");

        // Partial byte then a normal frame
        beginScen();
        drive(1'b0, 330);
        sendBits(8'hA5, 5);
        drive(1'b0, 330);
        sendBits(8'hA5, 8);
        drive(1'b0, 330);
        expPush(3, 2, 0); expPush(1, 8'hA5, 0); expPush(2, 1, 0);
        compareQ("partial");
        chk("partial errorCode", int'(errorCode), 2);

        // Overflow: one error per frame, frameBytes clamps
        beginScen();
        drive(1'b0, 330);
        sendBits(8'h01, 8); sendBits(8'h02, 8); sendBits(8'h03, 8); sendBits(8'h04, 8);
        drive(1'b0, 330);
        sendBits(8'h07, 8); sendBits(8'h08, 8); sendBits(8'h09, 8);
        drive(1'b0, 330);
        expPush(1, 1, 0); expPush(1, 2, 1); expPush(3, 3, 0); expPush(2, 2, 0);
        expPush(1, 7, 0); expPush(1, 8, 1); expPush(3, 3, 0); expPush(2, 2, 0);
        compareQ("overflow");
        chk("overflow frameBytes", int'(frameBytes), 2);
        chk("overflow dataOut", int'(dataOut), 8);

        // Disruption mid-byte by reset, then by enable
        for (int k = 0; k < 2; k++) begin
            beginScen();
            drive(1'b0, 330);
            sendBits(8'hA0, 3);
            drive(1'b1, 2);
            chk($sformatf("disrupt%0d busy before", k), int'(busy), 1);
            doReset(k == 1, $sformatf("disrupt%0d", k));
            drive(1'b0, 330);
            sendBits(8'hC3, 8);
            drive(1'b0, 330);
            expPush(1, 8'hC3, 0); expPush(2, 1, 0);
            compareQ($sformatf("disrupt%0d", k));
        end

        // No sync after reset: pulses are ignored
        beginScen();
        doReset(1'b0, "nosync");
        drive(1'b0, 100);
        sendBits(8'hA5, 8);
        drive(1'b0, 10);
        chk("nosync busy", int'(busy), 0);
        drive(1'b0, 330);
        compareQ("nosync");

        // Randomised frames against the pulse-level model
        for (int f = 0; f < 25; f++) begin
            beginScen();
            drive(1'b0, 330);
            nb = $urandom_range(0, 4);
            for (int b = 0; b < nb; b++) begin
                for (int i = 0; i < 8; i++) begin
                    bitv = $urandom_range(0, 1);
                    r = $urandom_range(0, 39);
                    if (r == 0)        h = 8;
                    else if (bitv != 0) h = $urandom_range(T1, MAXH);
                    else               h = $urandom_range(1, T1 - 1);
                    r = $urandom_range(0, 29);
                    if (r == 0)      g = SYNC - 1;
                    else if (r == 1) g = SYNC;
                    else             g = $urandom_range(1, 10);
                    drive(1'b1, h);
                    drive(1'b0, g);
                end
            end
            drive(1'b0, 330);
            expQ = modelQ;
            compareQ($sformatf("rand%0d", f));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
